mult_seq: RTL



---
 rtl/mult_seq_if.sv | 22 ++
 rtl/mult_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mult_seq_if.sv
// mult_seq_if: request/result bundle for the sequential 32x32 multiplier.
// master = execute stage issuing operations, slave = the multiplier.
interface mult_seq_if;
  logic        start;
  logic        signed_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_seq.sv
// mult_seq: iterative shift-add 32x32->64 multiplier for MULT/MULTU.
// One 33-bit add per cycle, 32 RUN cycles plus one FIX cycle (33 clocks
// start-to-result). Results land in HI/LO registers.
// Build option: define MULT_SIGNED_EN to honour signed_op (sign-magnitude
// capture plus 64-bit negation in FIX); otherwise every op is MULTU.
module mult_seq (
  input  logic        clk,
  input  logic        rst,
  mult_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] prod_lo_q, prod_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic [32:0] sum;
  logic [63:0] prod;
  logic [63:0] result;
  logic [31:0] mcand_in;
  logic [31:0] mplier_in;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;
  logic neg_in;

  // Magnitude of a two's complement word; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // Operand conditioning at capture: magnitudes plus product sign
  always_comb begin
    if (bus.signed_op) begin
      mcand_in  = mag(bus.a);
      mplier_in = mag(bus.b);
      neg_in    = bus.a[31] ^ bus.b[31];
    end else begin
      mcand_in  = bus.a;
      mplier_in = bus.b;
      neg_in    = 1'b0;
    end
  end

  assign result = neg_q ? (~prod + 64'd1) : prod;
`else
  logic unused_signed_op;

  assign unused_signed_op = bus.signed_op;
  assign mcand_in         = bus.a;
  assign mplier_in        = bus.b;
  assign result           = prod;
`endif

  assign prod = {acc_q, prod_lo_q};
  assign sum  = {1'b0, acc_q} + (prod_lo_q[0] ? {1'b0, mcand_q} : 33'd0);

  // Next-state and datapath updates; everything holds unless a state acts
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    prod_lo_d = prod_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
`ifdef MULT_SIGNED_EN
    neg_d     = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d   = mcand_in;
          prod_lo_d = mplier_in;
          acc_d     = '0;
          cnt_d     = '0;
`ifdef MULT_SIGNED_EN
          neg_d     = neg_in;
`endif
          state_d   = RUN;
        end
      end
      RUN: begin
        // {acc,prod_lo} <- {sum,prod_lo} >> 1, carry kept in acc[31]
        acc_d     = sum[32:1];
        prod_lo_d = {sum[0], prod_lo_q[31:1]};
        cnt_d     = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end
      FIX: begin
        hi_d    = result[63:32];
        lo_d    = result[31:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      prod_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      prod_lo_q <= prod_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
`ifdef MULT_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
